// File: rtl/ilvn_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ilvn_pkg
// Purpose  : Shared mode encodings, bit-mix index helpers and fill counter width
//            for the ilvn N-lane interleaver.
// Revision : 1.0 - initial release
// =============================================================================
package ilvn_pkg;

    typedef enum logic [1:0] {
        MODE_BYP  = 2'b00,
        MODE_ILV  = 2'b01,
        MODE_DILV = 2'b10,
        MODE_RSV  = 2'b11
    } mode_e;

    // Wide enough for a saturating count up to LANES-1 with LANES <= 16
    localparam int FILL_W = 4;

    // Output bit position of lane k bit i after mixing
    function automatic int mix_idx(input int i, input int k, input int lanes);
        return i * lanes + k;
    endfunction

    // Input bit position holding lane k bit i before unmixing
    function automatic int unmix_idx(input int i, input int k, input int lanes);
        return i * lanes + k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ilvn_if.sv
`default_nettype none
// =============================================================================
// Module   : ilvn_if
// Purpose  : Data/control bundle of the ilvn interleaver; slave = datapath side.
// Revision : 1.0 - initial release
// =============================================================================
interface ilvn_if #(
    parameter int WIDTH = 40
);
    logic [1:0]       mode;
    logic             flush;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             primed;
    logic             cfg_err;

    modport master (
        output mode, flush, din_valid, din,
        input  dout_valid, dout, primed, cfg_err
    );

    modport slave (
        input  mode, flush, din_valid, din,
        output dout_valid, dout, primed, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/ilvn_lane_dly.sv
`default_nettype none
// =============================================================================
// Module   : ilvn_lane_dly
// Purpose  : Per-lane delay line of DEPTH valid beats with zero-fill clear.
// Revision : 1.0 - initial release
// =============================================================================
module ilvn_lane_dly #(
    parameter int LW    = 20,
    parameter int DEPTH = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          en,
    input  wire logic          clr,
    input  wire logic [LW-1:0] d,
    output logic      [LW-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n, en, clr};
        assign q        = d;
    end else begin : g_dly
        logic [LW-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
            end else if (clr) begin
                // A beat arriving with the clear becomes the first beat of a fresh line
                for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
                if (en) r_stage[0] <= d;
            end else if (en) begin
                r_stage[0] <= d;
                for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
            end
        end

        // Older history reads as zero on the clearing beat
        assign q = clr ? '0 : r_stage[DEPTH-1];
    end
endmodule
`default_nettype wire

// File: rtl/ilvn.sv
`default_nettype none
// =============================================================================
// Module   : ilvn
// Purpose  : LANES-lane bit interleaver / deinterleaver with valid, flush, primed.
// Revision : 1.0 - initial release
// =============================================================================
module ilvn
    import ilvn_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int LANES = 2
) (
    input wire logic clk,
    input wire logic rst_n,
    ilvn_if.slave    bus
);
    localparam int               LW         = WIDTH / LANES;
    localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(LANES - 1);

    logic [1:0]        r_mode_q;
    logic [FILL_W-1:0] r_fill;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dout_valid;
    logic              r_primed;
    logic              r_cfg_err;

    logic              w_clr;
    logic              w_ilv;
    logic              w_dilv;
    logic [FILL_W-1:0] w_fill_base;
    logic [LW-1:0]     w_unmix  [LANES];
    logic [LW-1:0]     w_q_ilv  [LANES];
    logic [LW-1:0]     w_q_dilv [LANES];
    logic [WIDTH-1:0]  w_mix;
    logic [WIDTH-1:0]  w_cat;
    logic [WIDTH-1:0]  w_dout_next;
    logic              w_primed_next;

    assign w_clr       = bus.flush | (bus.mode != r_mode_q);
    assign w_ilv       = (bus.mode == MODE_ILV);
    assign w_dilv      = (bus.mode == MODE_DILV);
    assign w_fill_base = w_clr ? '0 : r_fill;

    always_comb begin
        w_unmix = '{default: '0};
        for (int k = 0; k < LANES; k++)
            for (int i = 0; i < LW; i++)
                w_unmix[k][i] = bus.din[unmix_idx(i, k, LANES)];
    end

    // Two banks: lane k sits k deep when interleaving, LANES-1-k deep when deinterleaving
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ilvn_lane_dly #(.LW(LW), .DEPTH(k)) u_ilv (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.din_valid & w_ilv),
            .clr   (w_clr),
            .d     (bus.din[k*LW +: LW]),
            .q     (w_q_ilv[k])
        );
        ilvn_lane_dly #(.LW(LW), .DEPTH(LANES - 1 - k)) u_dilv (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.din_valid & w_dilv),
            .clr   (w_clr),
            .d     (w_unmix[k]),
            .q     (w_q_dilv[k])
        );
    end

    always_comb begin
        w_mix = '0;
        w_cat = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cat[k*LW +: LW] = w_q_dilv[k];
            for (int i = 0; i < LW; i++)
                w_mix[mix_idx(i, k, LANES)] = w_q_ilv[k][i];
        end
    end

    always_comb begin
        w_dout_next   = bus.din;
        w_primed_next = 1'b1;
        if (w_ilv) begin
            w_dout_next   = w_mix;
            w_primed_next = (w_fill_base == c_fill_max);
        end else if (w_dilv) begin
            w_dout_next   = w_cat;
            w_primed_next = (w_fill_base == c_fill_max);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q     <= '0;
            r_fill       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_primed     <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_mode_q     <= bus.mode;
            r_dout_valid <= bus.din_valid;
            r_cfg_err    <= (bus.mode == MODE_RSV) | (r_cfg_err & ~bus.flush);
            if (bus.din_valid && (w_fill_base != c_fill_max))
                r_fill <= w_fill_base + FILL_W'(1);
            else
                r_fill <= w_fill_base;
            if (bus.din_valid) begin
                r_dout   <= w_dout_next;
                r_primed <= w_primed_next;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.primed     = r_primed;
    assign bus.cfg_err    = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_ilvn.sv
`default_nettype none
// =============================================================================
// Module   : tb_ilvn
// Purpose  : Self-checking bench: vector table on an 8/2 instance, reset corner,
//            and a randomized 40/4 interleave->deinterleave round trip.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ilvn;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    ilvn_if #(.WIDTH(8))  if_s ();
    ilvn_if #(.WIDTH(40)) if_a ();
    ilvn_if #(.WIDTH(40)) if_b ();

    ilvn #(.WIDTH(8),  .LANES(2)) u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    ilvn #(.WIDTH(40), .LANES(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    ilvn #(.WIDTH(40), .LANES(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    assign if_b.din       = if_a.dout;
    assign if_b.din_valid = if_a.dout_valid;

    typedef struct {
        logic [1:0] mode;
        logic       flush;
        logic       v;
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        logic       ec;
    } vec_t;

    vec_t tbl [16];

    logic [39:0] hist [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Interleaver output for input beat m: lane k comes from beat m-k, bits spread by lane
    function automatic logic [39:0] ilv_model(input int m);
        logic [39:0] r;
        logic [39:0] src;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (m - k >= 0) begin
                src = hist[m-k];
                for (int i = 0; i < 10; i++) r[i*4 + k] = src[k*10 + i];
            end
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        va, vb;
        logic [39:0] d;
        int          na, nb;

        tbl[0]  = '{2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, 1'b0, 1'b1, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{2'd1, 1'b0, 1'b1, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3]  = '{2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[4]  = '{2'd1, 1'b0, 1'b1, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, 1'b0, 1'b1, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[9]  = '{2'd2, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[10] = '{2'd2, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[11] = '{2'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[12] = '{2'd3, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
        tbl[13] = '{2'd0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b1};
        tbl[14] = '{2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0};
        tbl[15] = '{2'd0, 1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};

        rst_n = 1'b0;
        if_s.mode = 2'd1; if_s.flush = 1'b0; if_s.din_valid = 1'b0; if_s.din = '0;
        if_a.mode = 2'd1; if_a.flush = 1'b0; if_a.din_valid = 1'b0; if_a.din = '0;
        if_b.mode = 2'd2; if_b.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            if_s.mode      = tbl[r].mode;
            if_s.flush     = tbl[r].flush;
            if_s.din_valid = tbl[r].v;
            if_s.din       = tbl[r].din;
            @(posedge clk); #1;
            chk($sformatf("row%0d dout_valid", r), 64'(if_s.dout_valid), 64'(tbl[r].ev));
            chk($sformatf("row%0d dout", r),       64'(if_s.dout),       64'(tbl[r].ed));
            chk($sformatf("row%0d primed", r),     64'(if_s.primed),     64'(tbl[r].ep));
            chk($sformatf("row%0d cfg_err", r),    64'(if_s.cfg_err),    64'(tbl[r].ec));
        end

        // Asynchronous reset in the middle of an interleave stream
        if_s.flush = 1'b0; if_s.mode = 2'd3; if_s.din_valid = 1'b1; if_s.din = 8'h5A;
        @(posedge clk); #1;
        if_s.mode = 2'd1; if_s.din = 8'hAA;
        @(posedge clk); #1;
        if_s.din = 8'h55;
        @(posedge clk); #1;
        chk("pre-reset primed",  64'(if_s.primed),  64'd1);
        chk("pre-reset cfg_err", 64'(if_s.cfg_err), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst dout_valid", 64'(if_s.dout_valid), 64'd0);
        chk("async rst dout",       64'(if_s.dout),       64'd0);
        chk("async rst primed",     64'(if_s.primed),     64'd0);
        chk("async rst cfg_err",    64'(if_s.cfg_err),    64'd0);
        @(posedge clk); #1;
        chk("held rst dout_valid",  64'(if_s.dout_valid), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst dout_valid", 64'(if_s.dout_valid), 64'd1);
        chk("post-rst primed",     64'(if_s.primed),     64'd0);
        chk("post-rst dout",       64'(if_s.dout),       64'h11);
        if_s.din_valid = 1'b0;

        // Randomized round trip: interleaver A feeding deinterleaver B
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        va = 1'b0; vb = 1'b0; na = 0; nb = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            chk("A dout_valid", 64'(if_a.dout_valid), 64'(va));
            chk("B dout_valid", 64'(if_b.dout_valid), 64'(vb));
            if (va) begin
                chk($sformatf("A dout beat%0d", na),   64'(if_a.dout),   64'(ilv_model(na)));
                chk($sformatf("A primed beat%0d", na), 64'(if_a.primed), 64'(na >= 3));
                na++;
            end
            if (vb) begin
                chk($sformatf("B dout beat%0d", nb),   64'(if_b.dout),
                    (nb >= 3) ? 64'(hist[nb-3]) : 64'd0);
                chk($sformatf("B primed beat%0d", nb), 64'(if_b.primed), 64'(nb >= 3));
                nb++;
            end
            vb = va;
            va = ($urandom_range(0, 9) < 7);
            d  = 40'({$urandom, $urandom});
            if_a.din_valid = va;
            if_a.din       = d;
            if (va) hist.push_back(d);
        end
        chk("round trip beats seen", 64'(nb > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ilvn.md
Name: ilvn

Overview:
- Parametrised N-lane bit interleaver/deinterleaver for the SL3 FEC datapath. Generalises the 2-lane, 1-beat-skew interleaver to LANES lanes.
- The word splits into LANES lanes. In interleave mode, lane k is delayed by k valid beats and lane bits are then mixed round-robin. Deinterleave mode is the exact inverse, aligning the lanes back up.
- Adds valid qualification, runtime mode select, flush, and a primed flag.

Parameters:
- WIDTH, 40: total data width in bits. Must be a multiple of LANES.
- LANES, 2: lane count, 1..16. Lane width is LW = WIDTH/LANES.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  operating mode: 00 bypass, 01 interleave, 10 deinterleave, 11 reserved.
- flush  in  1  synchronous clear of the delay lines and fill count.
- din_valid  in  1  input beat qualifier.
- din  in  WIDTH  input word; lane k occupies din[k*LW +: LW].
- dout_valid  out  1  output beat qualifier.
- dout  out  WIDTH  output word.
- primed  out  1  output beat contains no zero-fill data.
- cfg_err  out  1  sticky flag: reserved mode was seen.

Behaviour:
- Reset (rst_n=0): all delay stages, dout, dout_valid, primed, cfg_err, fill_cnt and mode_q go to 0.
- Latency: one clk from a din_valid beat to its dout_valid beat in every mode.
- Delay lines advance only on din_valid=1. Idle cycles hold all state, and dout_valid=0 on the next cycle. dout holds its last value when dout_valid=0.
- Mix mapping (interleave output): dout[i*LANES+k] = delayed lane k bit i, for i in 0..LW-1.
- Unmix (deinterleave input): lane k bit i = din[i*LANES+k].
- Interleave: lane k is taken from din, delayed k valid beats, then mixed.
- Deinterleave: din is unmixed, then lane k is delayed (LANES-1-k) valid beats and the lanes are concatenated.
- Bypass: dout = din registered, no delay, no mix. Delay lines are not advanced.
- Reserved mode (11): behaves as bypass and sets cfg_err. cfg_err clears only on flush or reset.
- LANES=1: interleave and deinterleave both reduce to bypass, and primed=1 on every output beat.
- fill_cnt counts valid beats since the last clear and saturates at LANES-1.
  - primed is registered with dout: 1 iff fill_cnt was already LANES-1 when the beat entered.
  - In bypass, primed=1.
- Clear event = flush=1, or mode != mode_q (mode_q is updated every cycle).
  - On a clear edge, all delay stages load 0 and fill_cnt loads 0.
  - If din_valid=1 in the same cycle, that beat is processed as the first beat after the clear: zeros for older stages, primed=0, fill_cnt becomes 1 (saturated at LANES-1).
- Reset asserted mid-stream: outputs drop to reset values immediately. There is no partial-beat output.

Decomposition:
- Package ilvn_pkg holds:
  - mode encodings: MODE_BYP, MODE_ILV, MODE_DILV, MODE_RSV;
  - mix_idx and unmix_idx functions (bit-index mapping);
  - the fill counter width constant.
- One sub-module, ilvn_lane_dly. Parameters LW and DEPTH (0..LANES-1; DEPTH=0 is a wire). Ports: clk, rst_n, en, clr, d, q.
- ilvn instantiates LANES copies in a generate loop. Each lane's depth is selected per mode via two banks, or one bank of depth LANES-1 with a tap mux.

Test Plan:
- WIDTH=8, LANES=2, mode=01, din A=0xF0 then B=0x0F (valid back-to-back) -> dout 0x00 with primed=0, then 0xFF with primed=1. Each dout_valid follows its din by 1 clk.
- Same parameters, mode=01, 0xF0 and 0x0F separated by 3 idle cycles -> identical dout values. dout_valid low during the gaps, and the delay line is not advanced by idle cycles.
- Round trip, WIDTH=40, LANES=4: ilvn mode=01 feeding ilvn mode=10, random valid stream with random gaps.
  - After 6 valid warm-up beats, the second instance outputs the input delayed by exactly 3 valid beats.
  - primed is high from the 4th beat of each stage onward.
- Mode 01->10 switch with din_valid=1 on the switch cycle -> delay lines cleared, and that beat comes out with primed=0. fill_cnt restarts; primed returns after LANES-1 further beats.
- mode=11, din 0x5A -> dout 0x5A after 1 clk and cfg_err=1, which stays set after mode returns to 00. A flush pulse clears cfg_err.
- rst_n low for one cycle mid-stream (asynchronous, between clock edges) -> dout, dout_valid, primed and cfg_err go to 0 immediately. The first beat after release has primed=0.
